mem_lsu: RTL and testbench

- Parametrised successor to the pipeline memory stage; sits between the exe_mem and mem_wb pipeline registers.
- Replaces the combinational read-modify-write store path with a byte-strobe bus master using a req/ack handshake with multi-cycle wait states.
- Adds misalignment detection, bus error and timeout reporting, and a stall output to the pipeline.
- Bus width is configurable (32 or 64 bit); the register file stays 32-bit.

---
 rtl/mem_lsu.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Memory stage load/store unit: byte-strobe bus master with req/ack handshake,
// misalignment detection, bus error / timeout reporting and pipeline stall.
module mem_lsu #(
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic                    valid_in,
    input  logic [31:0]             reg_wdata_in,
    input  logic [4:0]              reg_waddr_in,
    input  logic                    reg_we_in,
    input  logic [3:0]              mem_op_in,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_in,
    input  logic [31:0]             mem_data_in,
    output logic                    stall_out,
    output logic                    bus_req_out,
    output logic                    bus_we_out,
    output logic [ADDR_WIDTH-1:0]   bus_addr_out,
    output logic [BUS_WIDTH-1:0]    bus_wdata_out,
    output logic [BUS_WIDTH/8-1:0]  bus_be_out,
    input  logic [BUS_WIDTH-1:0]    bus_rdata_in,
    input  logic                    bus_ack_in,
    input  logic                    bus_err_in,
    output logic                    valid_out,
    output logic [31:0]             reg_wdata_out,
    output logic [4:0]              reg_waddr_out,
    output logic                    reg_we_out,
    output logic                    misalign_out,
    output logic                    bus_err_out
);

    localparam int BE_W = BUS_WIDTH / 8;
    localparam int OFS  = $clog2(BE_W);
    localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [3:0] OP_LB  = 4'h1;
    localparam logic [3:0] OP_LH  = 4'h2;
    localparam logic [3:0] OP_LW  = 4'h3;
    localparam logic [3:0] OP_LBU = 4'h4;
    localparam logic [3:0] OP_LHU = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h6;
    localparam logic [3:0] OP_SH  = 4'h7;
    localparam logic [3:0] OP_SW  = 4'h8;

    typedef enum logic {IDLE, REQ} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [3:0]          op_q;
    logic [OFS-1:0]      lane_q;
    logic [4:0]          waddr_q;
    logic                we_q;

    logic                is_load, is_store, is_mem;
    logic                is_byte, is_half, is_word;
    logic                misalign;
    logic [OFS-1:0]      lane;
    logic [BUS_WIDTH-1:0] st_wdata;
    logic [BE_W-1:0]     st_be;
    logic                accept, expire, stall_raw;
    logic [31:0]         ld_data;

    assign lane = mem_addr_in[OFS-1:0];

    // Classify the incoming op by kind and access size
    always_comb begin
        is_load  = (mem_op_in == OP_LB) || (mem_op_in == OP_LBU) ||
                   (mem_op_in == OP_LH) || (mem_op_in == OP_LHU) ||
                   (mem_op_in == OP_LW);
        is_store = (mem_op_in == OP_SB) || (mem_op_in == OP_SH) ||
                   (mem_op_in == OP_SW);
        is_mem   = is_load || is_store;
        is_byte  = (mem_op_in == OP_LB) || (mem_op_in == OP_LBU) ||
                   (mem_op_in == OP_SB);
        is_half  = (mem_op_in == OP_LH) || (mem_op_in == OP_LHU) ||
                   (mem_op_in == OP_SH);
        is_word  = (mem_op_in == OP_LW) || (mem_op_in == OP_SW);
        misalign = (is_half && mem_addr_in[0]) ||
                   (is_word && (mem_addr_in[1:0] != 2'b00));
    end

    // Build lane-replicated store data and byte strobes
    always_comb begin
        st_wdata = '0;
        st_be    = '0;
        if (is_store) begin
            unique case (1'b1)
                is_byte: begin
                    st_wdata = {BE_W{mem_data_in[7:0]}};
                    st_be    = BE_W'(1) << lane;
                end
                is_half: begin
                    st_wdata = {(BUS_WIDTH/16){mem_data_in[15:0]}};
                    st_be    = BE_W'(2'b11) << lane;
                end
                is_word: begin
                    st_wdata = {(BUS_WIDTH/32){mem_data_in}};
                    st_be    = BE_W'(4'hF) << lane;
                end
                default: begin
                    st_wdata = '0;
                    st_be    = '0;
                end
            endcase
        end
    end

    // Extract and extend the addressed lane of the read data
    always_comb begin
        ld_data = '0;
        case (op_q)
            OP_LB:   ld_data = {{24{bus_rdata_in[{lane_q, 3'b000} + 7]}},
                                bus_rdata_in[{lane_q, 3'b000} +: 8]};
            OP_LBU:  ld_data = {24'b0, bus_rdata_in[{lane_q, 3'b000} +: 8]};
            OP_LH:   ld_data = {{16{bus_rdata_in[{lane_q, 3'b000} + 15]}},
                                bus_rdata_in[{lane_q, 3'b000} +: 16]};
            OP_LHU:  ld_data = {16'b0, bus_rdata_in[{lane_q, 3'b000} +: 16]};
            default: ld_data = bus_rdata_in[{lane_q, 3'b000} +: 32];
        endcase
    end

    // State register
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Next state, accept/expire strobes and stall
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        expire    = 1'b0;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in && is_mem && !misalign) begin
                    accept    = 1'b1;
                    stall_raw = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                expire    = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST) &&
                            !bus_ack_in;
                stall_raw = !bus_ack_in && !expire;
                if (bus_ack_in || expire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_out   = stall_raw && reset_n_in;
    assign bus_req_out = (state_q == REQ);

    // Wait counter: cleared on accept, counts every REQ cycle
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in)        cnt_q <= '0;
        else if (accept)        cnt_q <= '0;
        else if (state_q == REQ) cnt_q <= cnt_q + 1'b1;
    end

    // Capture the access and produce the registered writeback result
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            op_q          <= '0;
            lane_q        <= '0;
            waddr_q       <= '0;
            we_q          <= 1'b0;
            bus_we_out    <= 1'b0;
            bus_addr_out  <= '0;
            bus_wdata_out <= '0;
            bus_be_out    <= '0;
            valid_out     <= 1'b0;
            reg_wdata_out <= '0;
            reg_waddr_out <= '0;
            reg_we_out    <= 1'b0;
            misalign_out  <= 1'b0;
            bus_err_out   <= 1'b0;
        end else begin
            valid_out    <= 1'b0;
            reg_we_out   <= 1'b0;
            misalign_out <= 1'b0;
            bus_err_out  <= 1'b0;
            if (state_q == IDLE && valid_in) begin
                if (!is_mem) begin
                    valid_out     <= 1'b1;
                    reg_wdata_out <= reg_wdata_in;
                    reg_waddr_out <= reg_waddr_in;
                    reg_we_out    <= reg_we_in;
                end else if (misalign) begin
                    valid_out     <= 1'b1;
                    misalign_out  <= 1'b1;
                    reg_waddr_out <= reg_waddr_in;
                end else begin
                    op_q          <= mem_op_in;
                    lane_q        <= lane;
                    waddr_q       <= reg_waddr_in;
                    we_q          <= reg_we_in && is_load;
                    bus_we_out    <= is_store;
                    bus_addr_out  <= mem_addr_in & ~ADDR_WIDTH'(BE_W - 1);
                    bus_wdata_out <= st_wdata;
                    bus_be_out    <= st_be;
                end
            end
            if (state_q == REQ && (bus_ack_in || expire)) begin
                valid_out     <= 1'b1;
                reg_waddr_out <= waddr_q;
                if (expire || bus_err_in) begin
                    bus_err_out <= 1'b1;
                end else begin
                    reg_we_out <= we_q;
                    if (we_q) reg_wdata_out <= ld_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a 32-bit bus instance with a short timeout
// and a 64-bit bus instance with the default timeout.
module tb_mem_lsu;

    localparam logic [3:0] NOP = 4'h0;
    localparam logic [3:0] LB  = 4'h1;
    localparam logic [3:0] LH  = 4'h2;
    localparam logic [3:0] LW  = 4'h3;
    localparam logic [3:0] LHU = 4'h5;
    localparam logic [3:0] SB  = 4'h6;
    localparam logic [3:0] SH  = 4'h7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_valid, a_we, a_ack, a_err;
    logic [31:0] a_wd, a_addr, a_data, a_rdata;
    logic [4:0]  a_wa;
    logic [3:0]  a_op;
    logic        a_stall, a_req, a_bwe, a_vo, a_rwe, a_mis, a_berr;
    logic [31:0] a_baddr, a_bwd, a_rwd;
    logic [3:0]  a_be;
    logic [4:0]  a_rwa;

    logic        b_valid, b_we, b_ack, b_err;
    logic [31:0] b_wd, b_addr, b_data;
    logic [63:0] b_rdata;
    logic [4:0]  b_wa;
    logic [3:0]  b_op;
    logic        b_stall, b_req, b_bwe, b_vo, b_rwe, b_mis, b_berr;
    logic [31:0] b_baddr, b_rwd;
    logic [63:0] b_bwd;
    logic [7:0]  b_be;
    logic [4:0]  b_rwa;

    mem_lsu #(.BUS_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_a (
        .clk_in(clk), .reset_n_in(rst_n), .valid_in(a_valid),
        .reg_wdata_in(a_wd), .reg_waddr_in(a_wa), .reg_we_in(a_we),
        .mem_op_in(a_op), .mem_addr_in(a_addr), .mem_data_in(a_data),
        .stall_out(a_stall), .bus_req_out(a_req), .bus_we_out(a_bwe),
        .bus_addr_out(a_baddr), .bus_wdata_out(a_bwd), .bus_be_out(a_be),
        .bus_rdata_in(a_rdata), .bus_ack_in(a_ack), .bus_err_in(a_err),
        .valid_out(a_vo), .reg_wdata_out(a_rwd), .reg_waddr_out(a_rwa),
        .reg_we_out(a_rwe), .misalign_out(a_mis), .bus_err_out(a_berr)
    );

    mem_lsu #(.BUS_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut_b (
        .clk_in(clk), .reset_n_in(rst_n), .valid_in(b_valid),
        .reg_wdata_in(b_wd), .reg_waddr_in(b_wa), .reg_we_in(b_we),
        .mem_op_in(b_op), .mem_addr_in(b_addr), .mem_data_in(b_data),
        .stall_out(b_stall), .bus_req_out(b_req), .bus_we_out(b_bwe),
        .bus_addr_out(b_baddr), .bus_wdata_out(b_bwd), .bus_be_out(b_be),
        .bus_rdata_in(b_rdata), .bus_ack_in(b_ack), .bus_err_in(b_err),
        .valid_out(b_vo), .reg_wdata_out(b_rwd), .reg_waddr_out(b_rwa),
        .reg_we_out(b_rwe), .misalign_out(b_mis), .bus_err_out(b_berr)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_issue(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] wa,
                           input logic we);
        a_valid = 1'b1; a_op = op; a_addr = addr;
        a_data = data; a_wa = wa; a_we = we;
    endtask

    initial begin
        a_valid = 0; a_we = 0; a_ack = 0; a_err = 0; a_wd = 0;
        a_addr = 0; a_data = 0; a_rdata = 0; a_wa = 0; a_op = NOP;
        b_valid = 0; b_we = 0; b_ack = 0; b_err = 0; b_wd = 0;
        b_addr = 0; b_data = 0; b_rdata = 0; b_wa = 0; b_op = NOP;

        // reset state
        #1;
        chk("rst_req", a_req, 0);
        chk("rst_vo", a_vo, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_be", a_be, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // LB 0x103, three wait cycles then ack
        a_issue(LB, 32'h103, 32'h0, 5'd5, 1'b1);
        #1;
        chk("lb_stall0", a_stall, 1);
        chk("lb_noreq0", a_req, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lb_wait_stall", a_stall, 1);
            chk("lb_wait_req", a_req, 1);
            tick();
        end
        chk("lb_addr", a_baddr, 32'h100);
        chk("lb_be", a_be, 4'h0);
        chk("lb_we", a_bwe, 0);
        a_ack = 1; a_rdata = 32'h80112233;
        #1;
        chk("lb_ack_stall", a_stall, 0);
        tick();
        a_valid = 0; a_ack = 0;
        chk("lb_vo", a_vo, 1);
        chk("lb_data", a_rwd, 32'hFFFFFF80);
        chk("lb_rwe", a_rwe, 1);
        chk("lb_rwa", a_rwa, 5);
        chk("lb_req_off", a_req, 0);
        tick();
        chk("lb_vo_pulse", a_vo, 0);

        // misaligned LW 0x102
        a_issue(LW, 32'h102, 32'h0, 5'd6, 1'b1);
        #1;
        chk("mis_stall", a_stall, 0);
        tick();
        a_valid = 0;
        chk("mis_req", a_req, 0);
        chk("mis_vo", a_vo, 1);
        chk("mis_flag", a_mis, 1);
        chk("mis_rwe", a_rwe, 0);
        tick();
        chk("mis_pulse", a_mis, 0);

        // SB 0xA5 at 0x101
        a_issue(SB, 32'h101, 32'h12345AA5, 5'd0, 1'b0);
        tick();
        chk("sb_wdata", a_bwd, 32'hA5A5A5A5);
        chk("sb_be", a_be, 4'h2);
        chk("sb_we", a_bwe, 1);
        chk("sb_addr", a_baddr, 32'h100);
        a_ack = 1;
        tick();
        a_valid = 0; a_ack = 0;
        chk("sb_vo", a_vo, 1);
        chk("sb_rwe", a_rwe, 0);

        // timeout after 4 REQ cycles
        a_issue(LW, 32'h10, 32'h0, 5'd7, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_req", a_req, 1);
            chk("to_stall", a_stall, (i == 3) ? 1'b0 : 1'b1);
            tick();
        end
        a_valid = 0;
        chk("to_req_drop", a_req, 0);
        chk("to_vo", a_vo, 1);
        chk("to_err", a_berr, 1);
        chk("to_rwe", a_rwe, 0);

        // slave error with ack
        a_issue(LH, 32'h22, 32'h0, 5'd8, 1'b1);
        tick();
        a_ack = 1; a_err = 1; a_rdata = 32'h55AA55AA;
        tick();
        a_valid = 0; a_ack = 0; a_err = 0;
        chk("err_vo", a_vo, 1);
        chk("err_flag", a_berr, 1);
        chk("err_rwe", a_rwe, 0);

        // reset mid-REQ
        a_issue(LW, 32'h30, 32'h0, 5'd9, 1'b1);
        tick();
        chk("mr_req", a_req, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_req_drop", a_req, 0);
        chk("mr_stall", a_stall, 0);
        tick(); tick();
        a_valid = 0;
        rst_n = 1'b1;
        tick();
        chk("mr_no_vo", a_vo, 0);
        chk("mr_idle", a_req, 0);

        // ADD then LHU 0x40 with immediate ack
        a_valid = 1; a_op = NOP; a_wd = 32'h12345678; a_wa = 5'd3; a_we = 1;
        #1;
        chk("add_stall", a_stall, 0);
        tick();
        chk("add_vo", a_vo, 1);
        chk("add_data", a_rwd, 32'h12345678);
        chk("add_rwa", a_rwa, 3);
        chk("add_rwe", a_rwe, 1);
        a_issue(LHU, 32'h40, 32'h0, 5'd4, 1'b1);
        #1;
        chk("lhu_stall", a_stall, 1);
        tick();
        chk("lhu_gap_vo", a_vo, 0);
        a_ack = 1; a_rdata = 32'h9ABC1234;
        #1;
        chk("lhu_ack_stall", a_stall, 0);
        tick();
        a_valid = 0; a_ack = 0;
        chk("lhu_vo", a_vo, 1);
        chk("lhu_data", a_rwd, 32'h00001234);
        chk("lhu_rwa", a_rwa, 4);

        // 64-bit bus: SH 0xBEEF at 0x206
        b_valid = 1; b_op = SH; b_addr = 32'h206; b_data = 32'h0000BEEF;
        b_wa = 5'd9; b_we = 0;
        #1;
        chk("b_sh_stall", b_stall, 1);
        tick();
        chk("b_sh_req", b_req, 1);
        chk("b_sh_addr", b_baddr, 32'h200);
        chk("b_sh_be", b_be, 8'hC0);
        chk("b_sh_wdata", b_bwd, 64'hBEEFBEEFBEEFBEEF);
        chk("b_sh_we", b_bwe, 1);
        b_ack = 1;
        tick();
        b_valid = 0; b_ack = 0;
        chk("b_sh_vo", b_vo, 1);
        chk("b_sh_rwe", b_rwe, 0);

        // 64-bit bus: LW at 0x104 reads the upper word
        b_valid = 1; b_op = LW; b_addr = 32'h104; b_wa = 5'd10; b_we = 1;
        tick();
        chk("b_lw_be", b_be, 8'h00);
        chk("b_lw_addr", b_baddr, 32'h100);
        b_ack = 1; b_rdata = 64'h11223344_55667788;
        tick();
        b_valid = 0; b_ack = 0;
        chk("b_lw_vo", b_vo, 1);
        chk("b_lw_data", b_rwd, 32'h11223344);
        chk("b_lw_rwe", b_rwe, 1);
        chk("b_lw_mis", b_mis, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
